// File: rtl/adder_pkg.sv
// Shared constants and the per-stage payload carried down the adder pipeline.
package adder_pkg;

    localparam int unsigned DefWidth  = 64;
    localparam int unsigned DefStages = 4;

    // Payload fields are sized for DefWidth; an instance may use WIDTH <= DefWidth.
    // a/b hold the full operands (b already inverted for subtract) so each stage can
    // pick its own chunk; psum fills in one chunk per stage from the bottom up.
    typedef struct packed {
        logic                valid;
        logic                carry;
        logic [DefWidth-1:0] psum;
        logic [DefWidth-1:0] a;
        logic [DefWidth-1:0] b;
        logic                sub;
    } stage_t;

endpackage

// File: rtl/adder_stage.sv
// Combinational CW-bit ripple-carry chunk used once per pipeline stage.
module adder_stage #(
    parameter int unsigned CW = 16
) (
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          c_i,
    output logic [CW-1:0] s_o,
    output logic          c_o
);

    logic c;

    // Bit-serial ripple of the carry through the chunk.
    always_comb begin
        c   = c_i;
        s_o = '0;
        for (int i = 0; i < int'(CW); i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ c;
            c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        c_o = c;
    end

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined add/subtract: one CW-bit chunk per stage, valid/ready handshake with
// bubble-collapsing stalls. Optional overflow output under PIPELINED_CARRY_ADDER_OVF_EN.
module pipelined_carry_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned STAGES = DefStages
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned Last = STAGES - 1;

    logic [WIDTH-1:0]             b_eff;
    stage_t                       in_pl;
    stage_t                       s_q [STAGES];
    stage_t                       s_d [STAGES];
    logic [STAGES-1:0]            vld;
    logic [STAGES-1:0]            load;
    logic [STAGES-1:0][CW-1:0]    ch_a;
    logic [STAGES-1:0][CW-1:0]    ch_b;
    logic [STAGES-1:0][CW-1:0]    ch_s;
    logic [STAGES-1:0]            ch_ci;
    logic [STAGES-1:0]            ch_co;

    // Subtraction is in1 + ~in2 + 1; the +1 enters as stage-0 carry-in.
    assign b_eff = sub ? ~in2 : in2;

    // Payload presented to stage 0 from the input port.
    always_comb begin
        in_pl       = '0;
        in_pl.valid = in_valid;
        in_pl.a     = DefWidth'(in1);
        in_pl.b     = DefWidth'(b_eff);
        in_pl.sub   = sub;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign vld[k] = s_q[k].valid;
        // Stage k may load if any stage from k to the tail has a hole, or the tail drains.
        assign load[k] = out_ready | ~(&vld[Last:k]);

        if (k == 0) begin : g_first
            assign ch_a[k]  = in1[CW-1:0];
            assign ch_b[k]  = b_eff[CW-1:0];
            assign ch_ci[k] = sub | cin;
        end else begin : g_rest
            assign ch_a[k]  = s_q[k-1].a[k*CW +: CW];
            assign ch_b[k]  = s_q[k-1].b[k*CW +: CW];
            assign ch_ci[k] = s_q[k-1].carry;
        end

        adder_stage #(
            .CW (CW)
        ) u_stage (
            .a_i (ch_a[k]),
            .b_i (ch_b[k]),
            .c_i (ch_ci[k]),
            .s_o (ch_s[k]),
            .c_o (ch_co[k])
        );
    end

    // Next state: a loading stage takes its predecessor's payload plus its own chunk result.
    always_comb begin
        stage_t src;
        src = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            src    = (k == 0) ? in_pl : s_q[(k == 0) ? 0 : k - 1];
            s_d[k] = s_q[k];
            if (load[k]) begin
                s_d[k]                   = src;
                s_d[k].psum[k*CW +: CW] = ch_s[k];
                s_d[k].carry             = ch_co[k];
            end
        end
    end

    // Stage registers; reset clears everything so the outputs read zero at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                s_q[k] <= s_d[k];
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = s_q[Last].valid;
    assign sum       = s_q[Last].psum[WIDTH-1:0];
    assign cout      = s_q[Last].carry;

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    // Carry into the MSB is a^b^s at that bit; overflow when it differs from carry out.
    assign ovf = s_q[Last].a[WIDTH-1] ^ s_q[Last].b[WIDTH-1] ^
                 s_q[Last].psum[WIDTH-1] ^ s_q[Last].carry;
`endif

    // Tail operands and the sub flag are not consumed past the last stage.
    logic unused_tail;
    assign unused_tail = ^{s_q[Last].a, s_q[Last].b, s_q[Last].sub};

endmodule
